io_sequencer: RTL

IO_SEQUENCER -- requirements
Module: io_sequencer

---
 rtl/io_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/io_sequencer.sv
// io_sequencer: the handshake between the CPU and the user's IO.
// The button is synchronized and debounced into a single-cycle press pulse.
// A four-state FSM stalls the CPU while an IO instruction waits for that press.
// After an instruction completes, the FSM stays in DONE until the CPU retires it.
// This keeps an instruction that is still decoded from being executed twice.
module io_sequencer #(
  parameter int DEB_CYCLES = 16,
  parameter bit OUT_ACK    = 1'b0
) (
  input  logic        clk,
  input  logic        bt_reset,
  input  logic        inop,
  input  logic        outop,
  input  logic        sleep,
  input  logic        step,
  input  logic        bt,
  input  logic [13:0] in,
  input  logic [31:0] dm,
  output logic [31:0] du,
  output logic [31:0] disp_val,
  output logic        await,
  output logic        update
);

  localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IN_WAIT  = 2'd1,
    OUT_WAIT = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          sync1;
  logic          sync2;
  logic          deb_level;
  logic [CW-1:0] deb_cnt;
  logic          press;
  logic          load_du;
  logic          load_disp;

  // Button synchronizer, then a debounce counter that accepts a new level
  // only after it has differed from the current one for DEB_CYCLES cycles.
  // press fires on the edge where the accepted level rises.
  always_ff @(posedge clk or negedge bt_reset) begin
    if (!bt_reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      deb_level <= 1'b0;
      deb_cnt   <= '0;
      press     <= 1'b0;
    end else begin
      sync1 <= bt;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 != deb_level) begin
        if (deb_cnt == CW'(DEB_CYCLES - 1)) begin
          deb_level <= sync2;
          deb_cnt   <= '0;
          press     <= sync2;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge bt_reset) begin
    if (!bt_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, stall request and latch strobes. inop wins over outop.
  always_comb begin
    state_next = state;
    await      = 1'b0;
    load_du    = 1'b0;
    load_disp  = 1'b0;
    case (state)
      IDLE: begin
        if (inop) begin
          await      = 1'b1;
          state_next = IN_WAIT;
        end else if (outop) begin
          await      = OUT_ACK;
          load_disp  = 1'b1;
          state_next = OUT_ACK ? OUT_WAIT : DONE;
        end
      end
      IN_WAIT: begin
        await = 1'b1;
        if (press) begin
          load_du    = 1'b1;
          state_next = DONE;
        end
      end
      OUT_WAIT: begin
        await = 1'b1;
        if (press) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (step) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Data registers hold their values until the FSM strobes a new load.
  always_ff @(posedge clk or negedge bt_reset) begin
    if (!bt_reset) begin
      du       <= '0;
      disp_val <= '0;
    end else begin
      if (load_du) begin
        du <= {18'b0, in};
      end
      if (load_disp) begin
        disp_val <= dm;
      end
    end
  end

  assign update = ~(sleep | await);

endmodule
